// File: rtl/fetch_aggregator_pkg.sv
// Shared defaults and width-clamp helper for the fetch aggregator.
package fetch_aggregator_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_FETCH_WIDTH = 6;
  localparam int unsigned DEF_FW_BITS     = $clog2(DEF_FETCH_WIDTH + 1);

  // A request of 0 or above the lane count means "use every lane".
  function automatic int unsigned clamp_width(input int unsigned w, input int unsigned max_w);
    return ((w == 0) || (w > max_w)) ? max_w : w;
  endfunction

endpackage

// File: rtl/fetch_aggregator.sv
// Packs narrow words popped from an upstream FIFO into a wide multi-lane packet
// whose lane count is selectable at run time and switches only between packets.
module fetch_aggregator
  import fetch_aggregator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned FETCH_WIDTH = DEF_FETCH_WIDTH,
  localparam int unsigned FW_BITS    = $clog2(FETCH_WIDTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH-1:0]             sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  input  logic                              change_fetch_width,
  input  logic [FW_BITS-1:0]                input_fetch_width
);

  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] lane_q, lane_d;
  logic [FW_BITS-1:0] count_q, count_d;
  logic [FW_BITS-1:0] active_w_q, active_w_d;
  logic [FW_BITS-1:0] pending_w_q, pending_w_d;
  logic               pending_q, pending_d;

  logic [FW_BITS-1:0] req_w_c;
  logic [FW_BITS-1:0] wr_idx_c;
  logic               full_c;
  logic               boundary_c;

  assign req_w_c       = FW_BITS'(clamp_width(32'(input_fetch_width), FETCH_WIDTH));
  assign receiver_data = lane_q;

  // Handshakes: forced low in reset so nothing moves while rst_n is asserted.
  always_comb begin
    full_c       = (count_q == active_w_q);
    receiver_enq = rst_n & full_c & receiver_full_n;
    sender_deq   = rst_n & sender_empty_n & ((count_q < active_w_q) | receiver_enq);
  end

  // Next state: consume packet, append word, apply pending width at a boundary.
  always_comb begin
    lane_d      = lane_q;
    count_d     = count_q;
    active_w_d  = active_w_q;
    pending_w_d = pending_w_q;
    pending_d   = pending_q;
    wr_idx_c    = receiver_enq ? '0 : count_q;
    boundary_c  = (count_q == '0) || receiver_enq;

    // Clearing on consume keeps lanes beyond the active width at zero.
    if (receiver_enq) begin
      lane_d  = '0;
      count_d = '0;
    end

    if (sender_deq) begin
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
        if (FW_BITS'(i) == wr_idx_c) lane_d[i] = sender_data;
      end
      count_d = wr_idx_c + FW_BITS'(1);
    end

    if (boundary_c && pending_q) begin
      active_w_d = pending_w_q;
      pending_d  = 1'b0;
    end

    // A new request lands in pending and waits for the following boundary.
    if (change_fetch_width) begin
      pending_w_d = req_w_c;
      pending_d   = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q      <= '0;
      count_q     <= '0;
      active_w_q  <= FW_BITS'(FETCH_WIDTH);
      pending_w_q <= FW_BITS'(FETCH_WIDTH);
      pending_q   <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      count_q     <= count_d;
      active_w_q  <= active_w_d;
      pending_w_q <= pending_w_d;
      pending_q   <= pending_d;
    end
  end

endmodule

// File: tb/tb_fetch_aggregator.sv
// Randomised and directed bench for fetch_aggregator against a queue-based model.
module tb_fetch_aggregator;
  import fetch_aggregator_pkg::*;

  localparam int unsigned DW = DEF_DATA_WIDTH;
  localparam int unsigned FW = DEF_FETCH_WIDTH;
  localparam int unsigned WB = DEF_FW_BITS;
  localparam int unsigned RW = FW * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] sender_data = '0;
  logic          sender_empty_n = 1'b0;
  logic          sender_deq;
  logic [RW-1:0] receiver_data;
  logic          receiver_full_n = 1'b0;
  logic          receiver_enq;
  logic          change_fetch_width = 1'b0;
  logic [WB-1:0] input_fetch_width = '0;

  fetch_aggregator dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .sender_data        (sender_data),
    .sender_empty_n     (sender_empty_n),
    .sender_deq         (sender_deq),
    .receiver_data      (receiver_data),
    .receiver_full_n    (receiver_full_n),
    .receiver_enq       (receiver_enq),
    .change_fetch_width (change_fetch_width),
    .input_fetch_width  (input_fetch_width)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: words gathered for the packet in progress, plus width state.
  int unsigned words[$];
  int unsigned act = FW;
  int unsigned pend_w = FW;
  bit          pend = 1'b0;
  int unsigned src = 0;
  int unsigned pkts = 0;

  function automatic int unsigned model_clamp(input int unsigned w);
    if (w == 0 || w > FW) return FW;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at a falling edge; drives inputs, checks, advances model across the next rising edge.
  task automatic step(input bit empty_n, input bit full_n, input bit chg, input int unsigned w);
    logic [RW-1:0] exp_data;
    bit exp_enq, exp_deq, was_empty;
    sender_empty_n     = empty_n;
    receiver_full_n    = full_n;
    change_fetch_width = chg;
    input_fetch_width  = WB'(w);
    sender_data        = DW'(src);
    #1;
    exp_enq  = (words.size() == act) && full_n;
    exp_deq  = empty_n && ((words.size() < act) || exp_enq);
    exp_data = '0;
    foreach (words[i]) exp_data[i*DW +: DW] = DW'(words[i]);
    chk("enq", RW'(receiver_enq), RW'(exp_enq));
    chk("deq", RW'(sender_deq), RW'(exp_deq));
    chk("data", receiver_data, exp_data);
    was_empty = (words.size() == 0);
    if (exp_enq) begin
      words.delete();
      pkts++;
    end
    if (exp_deq) begin
      words.push_back(src);
      src++;
    end
    if ((was_empty || exp_enq) && pend) begin
      act  = pend_w;
      pend = 1'b0;
    end
    if (chg) begin
      pend_w = model_clamp(w);
      pend   = 1'b1;
    end
    @(negedge clk);
  endtask

  // Entered at a falling edge; asserts reset with live handshakes, checks, releases.
  task automatic do_reset();
    sender_empty_n     = 1'b1;
    receiver_full_n    = 1'b1;
    change_fetch_width = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_enq", RW'(receiver_enq), '0);
    chk("rst_deq", RW'(sender_deq), '0);
    chk("rst_data", receiver_data, '0);
    words.delete();
    act  = FW;
    pend = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned k;
    @(negedge clk);
    do_reset();

    // Default width, continuous upstream: 0..5 then 6..11.
    for (int i = 0; i < 16; i++) step(1, 1, 0, 0);
    chk("pkts_after_default", RW'(pkts), RW'(2));

    // Narrow to 2 lanes, then widen to 4, mid-stream.
    step(1, 1, 1, 2);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 4);
    for (int i = 0; i < 14; i++) step(1, 1, 0, 0);

    // Fill a packet while the receiver refuses, hold 5 cycles, release.
    k = 0;
    while (words.size() != act && k < 20) begin
      step(1, 0, 0, 0);
      k++;
    end
    chk("fill_bound", RW'(words.size() == act), RW'(1));
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0);

    // Single-lane packets every cycle.
    step(1, 1, 1, 1);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);

    // Out-of-range widths fall back to all lanes.
    step(1, 1, 1, 0);
    for (int i = 0; i < 14; i++) step(1, 1, 0, 0);
    chk("clamp0_width", RW'(act), RW'(FW));
    step(1, 1, 1, 7);
    for (int i = 0; i < 14; i++) step(1, 1, 0, 0);
    chk("clamp7_width", RW'(act), RW'(FW));

    // Reset after 3 of 4 words, then resume at width 6 with the next word.
    step(1, 1, 1, 4);
    k = 0;
    while (!(act == 4 && words.size() == 3) && k < 20) begin
      step(1, 1, 0, 0);
      k++;
    end
    chk("midpkt_bound", RW'(act == 4 && words.size() == 3), RW'(1));
    do_reset();
    for (int i = 0; i < 14; i++) step(1, 1, 0, 0);

    // Random traffic, stalls and width requests.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), $urandom_range(0, 7));
    end
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_aggregator.md
Name: fetch_aggregator

Overview:
Packs a stream of DATA_WIDTH-bit words, popped from an upstream FIFO, into one wide word of up to FETCH_WIDTH lanes. The packed word goes to a downstream receiver.
The number of words per packet is selectable at run time through input_fetch_width / change_fetch_width.
It sits between a clock-domain-crossing FIFO (read side) and wide consumers such as patch or fetch buffers.
Single clock domain: the upstream FIFO read side is already in clk.

Parameters:
DATA_WIDTH, 8, bits per input word / per output lane
FETCH_WIDTH, 6, maximum lanes per packet (>=1)
FW_BITS, $clog2(FETCH_WIDTH+1) (=3), width of input_fetch_width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
sender_data  in  DATA_WIDTH  head word of upstream FIFO, valid while sender_empty_n=1
sender_empty_n  in  1  upstream FIFO has data
sender_deq  out  1  pop upstream FIFO this cycle; sender_data is captured on the same edge
receiver_data  out  FETCH_WIDTH*DATA_WIDTH  packed word; lane i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
receiver_full_n  in  1  receiver can accept a packet
receiver_enq  out  1  packet transfer this cycle
change_fetch_width  in  1  load input_fetch_width as the new packet size
input_fetch_width  in  FW_BITS  requested lanes per packet

Behaviour:
- Registers:
  - lane buffer: FETCH_WIDTH x DATA_WIDTH
  - count: 0..FETCH_WIDTH
  - active_w: packet size in use
  - pending_w plus pending flag
- Reset (async, rst_n=0):
  - lane buffer=0, count=0, active_w=FETCH_WIDTH, pending cleared.
  - sender_deq and receiver_enq are forced 0 while rst_n=0.
- Width clamp: a requested width of 0 or > FETCH_WIDTH is treated as FETCH_WIDTH.
- Width change:
  - change_fetch_width=1 at an edge latches the clamped input_fetch_width into pending_w and sets pending. A later request overwrites an earlier one.
  - pending_w is copied to active_w only at a packet boundary: at an edge where count==0, or where receiver_enq=1. pending is then cleared.
  - No word is dropped or duplicated across a width change.
- receiver_enq = (count==active_w) && receiver_full_n (combinational).
- sender_deq = sender_empty_n && ((count < active_w) || receiver_enq) (combinational).
- On an edge with sender_deq=1 and no enq:
  - sender_data is written to lane[count].
  - count increments.
- On an edge with receiver_enq=1:
  - The packet is consumed.
  - If sender_deq=1 in the same cycle, sender_data is written to lane[0] and count=1; otherwise count=0.
  - Sustained throughput: 1 word/cycle.
- receiver_data is the lane buffer itself.
  - Lanes >= active_w drive 0: clear the lanes when a packet starts.
  - First-received word is in lane 0, in order: lane i = first word + i.
- Latency: from the deq of the last word of a packet, receiver_enq can assert at the next cycle.
- Backpressure: while count==active_w and receiver_full_n=0, hold data and count; sender_deq=0.
- Empty upstream: count holds and no deq occurs. Partial packets are never emitted.
- Reset mid-packet: the partial packet is discarded and active_w returns to FETCH_WIDTH.

Decomposition:
- Shared package: DATA_WIDTH and FETCH_WIDTH defaults, plus a clamp_width function.
- A single flat module; no sub-module is needed.

Test Plan:
1. Reset, default width 6, upstream supplies 0,1,2,...
   -> first receiver_enq carries lanes 0..5 = 0..5; next packet = 6..11.
2. change_fetch_width pulse with input_fetch_width=2, then 4 mid-stream.
   -> packets 0,1 | 2,3 | then 4-lane packets continuing contiguously (e.g. 4..7, 8..11); lanes above the width read 0.
3. receiver_full_n=0 for 5 cycles while a packet is full.
   -> receiver_data stable, sender_deq=0. On release: single enq, next packet starts with the next word.
4. Width 1, continuous upstream.
   -> receiver_enq every cycle after the first; lane0 = 0,1,2,...; sender_deq high continuously.
5. input_fetch_width=0 and 7.
   -> behaves as width 6.
6. Assert rst_n=0 after 3 of 4 words.
   -> outputs zero immediately. After release, the next packet starts in lane 0 with the next upstream word, width 6.
